// File: rtl/alu_exec_unit_if.sv
// Shared widths/opcode encodings for the execute stage, plus the issue/CDB bundle
// between the reservation station side and the ALU.
package alu_exec_pkg;

    localparam int OPCODE_W = 6;
    localparam int ROB_ID_W = 4;
    localparam int DATA_W   = 32;

    typedef logic [OPCODE_W-1:0] opcode_t;

    localparam opcode_t OP_NOP   = 6'd0;
    localparam opcode_t OP_LUI   = 6'd1;
    localparam opcode_t OP_AUIPC = 6'd2;
    localparam opcode_t OP_JAL   = 6'd3;
    localparam opcode_t OP_JALR  = 6'd4;
    localparam opcode_t OP_BEQ   = 6'd5;
    localparam opcode_t OP_BNE   = 6'd6;
    localparam opcode_t OP_BLT   = 6'd7;
    localparam opcode_t OP_BGE   = 6'd8;
    localparam opcode_t OP_BLTU  = 6'd9;
    localparam opcode_t OP_BGEU  = 6'd10;
    localparam opcode_t OP_ADDI  = 6'd11;
    localparam opcode_t OP_SLTI  = 6'd12;
    localparam opcode_t OP_SLTIU = 6'd13;
    localparam opcode_t OP_XORI  = 6'd14;
    localparam opcode_t OP_ORI   = 6'd15;
    localparam opcode_t OP_ANDI  = 6'd16;
    localparam opcode_t OP_SLLI  = 6'd17;
    localparam opcode_t OP_SRLI  = 6'd18;
    localparam opcode_t OP_SRAI  = 6'd19;
    localparam opcode_t OP_ADD   = 6'd20;
    localparam opcode_t OP_SUB   = 6'd21;
    localparam opcode_t OP_SLL   = 6'd22;
    localparam opcode_t OP_SLT   = 6'd23;
    localparam opcode_t OP_SLTU  = 6'd24;
    localparam opcode_t OP_XOR   = 6'd25;
    localparam opcode_t OP_SRL   = 6'd26;
    localparam opcode_t OP_SRA   = 6'd27;
    localparam opcode_t OP_OR    = 6'd28;
    localparam opcode_t OP_AND   = 6'd29;

endpackage

interface alu_exec_unit_if;
    import alu_exec_pkg::*;

    opcode_t             optype_in;
    logic [ROB_ID_W-1:0] rd_in;
    logic [DATA_W-1:0]   pc_in;
    logic [DATA_W-1:0]   Vi_in;
    logic [DATA_W-1:0]   Vj_in;
    logic [DATA_W-1:0]   imm_in;

    logic                alu_has_result;
    logic [ROB_ID_W-1:0] alias_from_alu;
    logic [DATA_W-1:0]   result_from_alu;
    logic                jump_flag;
    logic [DATA_W-1:0]   target_pc;

    modport master (
        output optype_in, rd_in, pc_in, Vi_in, Vj_in, imm_in,
        input  alu_has_result, alias_from_alu, result_from_alu, jump_flag, target_pc
    );

    modport slave (
        input  optype_in, rd_in, pc_in, Vi_in, Vj_in, imm_in,
        output alu_has_result, alias_from_alu, result_from_alu, jump_flag, target_pc
    );

endinterface

// File: rtl/alu_exec_unit.sv
// Single-issue RV32I integer execute stage: combinational compute, one register
// stage onto the ALU CDB port, plus branch/jump resolution for the ROB.
module alu_exec_unit
    import alu_exec_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           rdy,
    input  logic           rollback_signal,
    alu_exec_unit_if.slave bus
);

    logic [DATA_W-1:0] vi;
    logic [DATA_W-1:0] vj;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;

    logic [DATA_W-1:0] pc_plus4;
    logic [DATA_W-1:0] pc_plus_imm;
    logic [DATA_W-1:0] jalr_sum;

    logic              branch_taken;

    logic              calc_valid;
    logic [DATA_W-1:0] calc_result;
    logic              calc_jump;
    logic [DATA_W-1:0] calc_target;

    logic                has_result_q;
    logic [ROB_ID_W-1:0] alias_q;
    logic [DATA_W-1:0]   result_q;
    logic                jump_q;
    logic [DATA_W-1:0]   target_q;

    assign vi  = bus.Vi_in;
    assign vj  = bus.Vj_in;
    assign imm = bus.imm_in;
    assign pc  = bus.pc_in;

    assign pc_plus4    = pc + 32'd4;
    assign pc_plus_imm = pc + imm;
    assign jalr_sum    = vi + imm;

    always_comb begin
        branch_taken = 1'b0;
        case (bus.optype_in)
            OP_BEQ:  branch_taken = (vi == vj);
            OP_BNE:  branch_taken = (vi != vj);
            OP_BLT:  branch_taken = ($signed(vi) <  $signed(vj));
            OP_BGE:  branch_taken = ($signed(vi) >= $signed(vj));
            OP_BLTU: branch_taken = (vi <  vj);
            OP_BGEU: branch_taken = (vi >= vj);
            default: branch_taken = 1'b0;
        endcase
    end

    // Unrecognised encodings fall into the default arm and behave exactly like NOP.
    always_comb begin
        calc_valid  = 1'b1;
        calc_result = '0;
        calc_jump   = 1'b0;
        calc_target = pc_plus4;
        case (bus.optype_in)
            OP_LUI:   calc_result = imm;
            OP_AUIPC: calc_result = pc_plus_imm;
            OP_JAL: begin
                calc_result = pc_plus4;
                calc_jump   = 1'b1;
                calc_target = pc_plus_imm;
            end
            OP_JALR: begin
                calc_result = pc_plus4;
                calc_jump   = 1'b1;
                calc_target = jalr_sum & 32'hFFFF_FFFE;
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                calc_result = '0;
                calc_jump   = branch_taken;
                calc_target = branch_taken ? pc_plus_imm : pc_plus4;
            end
            OP_ADDI:  calc_result = vi + imm;
            OP_SLTI:  calc_result = {31'd0, $signed(vi) < $signed(imm)};
            OP_SLTIU: calc_result = {31'd0, vi < imm};
            OP_XORI:  calc_result = vi ^ imm;
            OP_ORI:   calc_result = vi | imm;
            OP_ANDI:  calc_result = vi & imm;
            OP_SLLI:  calc_result = vi << imm[4:0];
            OP_SRLI:  calc_result = vi >> imm[4:0];
            OP_SRAI:  calc_result = $unsigned($signed(vi) >>> imm[4:0]);
            OP_ADD:   calc_result = vi + vj;
            OP_SUB:   calc_result = vi - vj;
            OP_SLL:   calc_result = vi << vj[4:0];
            OP_SLT:   calc_result = {31'd0, $signed(vi) < $signed(vj)};
            OP_SLTU:  calc_result = {31'd0, vi < vj};
            OP_XOR:   calc_result = vi ^ vj;
            OP_SRL:   calc_result = vi >> vj[4:0];
            OP_SRA:   calc_result = $unsigned($signed(vi) >>> vj[4:0]);
            OP_OR:    calc_result = vi | vj;
            OP_AND:   calc_result = vi & vj;
            default: begin
                calc_valid  = 1'b0;
                calc_result = '0;
                calc_jump   = 1'b0;
                calc_target = pc_plus4;
            end
        endcase
    end

    // Rollback wins even while paused so a flushed op can never reach the CDB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            has_result_q <= 1'b0;
            alias_q      <= '0;
            result_q     <= '0;
            jump_q       <= 1'b0;
            target_q     <= '0;
        end else if (rollback_signal) begin
            has_result_q <= 1'b0;
            jump_q       <= 1'b0;
        end else if (rdy) begin
            has_result_q <= calc_valid;
            alias_q      <= bus.rd_in;
            result_q     <= calc_result;
            jump_q       <= calc_jump;
            target_q     <= calc_target;
        end
    end

    assign bus.alu_has_result  = has_result_q;
    assign bus.alias_from_alu  = alias_q;
    assign bus.result_from_alu = result_q;
    assign bus.jump_flag       = jump_q;
    assign bus.target_pc       = target_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: hand-computed vectors for arithmetic, control
// transfer, back-to-back issue, rollback, pause and asynchronous reset.
module tb_alu_exec_unit;
    import alu_exec_pkg::*;

    logic clk;
    logic rst_n;
    logic rdy;
    logic rollback_signal;

    int check_count;
    int error_count;

    alu_exec_unit_if bus_if ();

    alu_exec_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rdy             (rdy),
        .rollback_signal (rollback_signal),
        .bus             (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  op;
        logic [3:0]  rd;
        logic [31:0] pc;
        logic [31:0] vi;
        logic [31:0] vj;
        logic [31:0] imm;
        logic [31:0] exp_result;
        logic        exp_jump;
        logic [31:0] exp_target;
    } vec_t;

    vec_t vecs[$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkCdb(input string tag, input logic valid, input logic [3:0] rd,
                            input logic [31:0] result, input logic jump, input logic [31:0] target);
        checkOutput({tag, ".valid"},  {31'd0, bus_if.alu_has_result}, {31'd0, valid});
        checkOutput({tag, ".alias"},  {28'd0, bus_if.alias_from_alu}, {28'd0, rd});
        checkOutput({tag, ".result"}, bus_if.result_from_alu, result);
        checkOutput({tag, ".jump"},   {31'd0, bus_if.jump_flag}, {31'd0, jump});
        checkOutput({tag, ".target"}, bus_if.target_pc, target);
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic [3:0] rd, input logic [31:0] pc,
                                 input logic [31:0] vi, input logic [31:0] vj, input logic [31:0] imm);
        bus_if.optype_in = op;
        bus_if.rd_in     = rd;
        bus_if.pc_in     = pc;
        bus_if.Vi_in     = vi;
        bus_if.Vj_in     = vj;
        bus_if.imm_in    = imm;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        check_count     = 0;
        error_count     = 0;
        rst_n           = 1'b0;
        rdy             = 1'b1;
        rollback_signal = 1'b0;
        applyStimulus(OP_NOP, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);

        vecs.push_back('{OP_ADD,   4'd5, 32'h200, 32'hFFFF_FFFF, 32'h2,         32'h0,         32'h0000_0001, 1'b0, 32'h204});
        vecs.push_back('{OP_SRA,   4'd6, 32'h204, 32'h8000_0000, 32'h24,        32'h0,         32'hF800_0000, 1'b0, 32'h208});
        vecs.push_back('{OP_SLTU,  4'd7, 32'h208, 32'h1,         32'hFFFF_FFFF, 32'h0,         32'h0000_0001, 1'b0, 32'h20C});
        vecs.push_back('{OP_SLT,   4'd8, 32'h20C, 32'h1,         32'hFFFF_FFFF, 32'h0,         32'h0000_0000, 1'b0, 32'h210});
        vecs.push_back('{OP_SUB,   4'd9, 32'h210, 32'h5,         32'h7,         32'h0,         32'hFFFF_FFFE, 1'b0, 32'h214});
        vecs.push_back('{OP_SRLI,  4'd3, 32'h214, 32'h8000_0000, 32'h0,         32'h1F,        32'h0000_0001, 1'b0, 32'h218});
        vecs.push_back('{OP_LUI,   4'd4, 32'h218, 32'h0,         32'h0,         32'h1234_5000, 32'h1234_5000, 1'b0, 32'h21C});
        vecs.push_back('{OP_AUIPC, 4'd2, 32'h1000, 32'h0,        32'h0,         32'h2000,      32'h0000_3000, 1'b0, 32'h1004});
        vecs.push_back('{OP_BLT,   4'd1, 32'h100, 32'hFFFF_FFFF, 32'h0,         32'h20,        32'h0,         1'b1, 32'h120});
        vecs.push_back('{OP_BGEU,  4'd1, 32'h100, 32'hFFFF_FFFF, 32'h0,         32'h20,        32'h0,         1'b1, 32'h120});
        vecs.push_back('{OP_BEQ,   4'd1, 32'h100, 32'h1,         32'h2,         32'h20,        32'h0,         1'b0, 32'h104});
        vecs.push_back('{OP_JALR,  4'd10, 32'h40, 32'h1001,      32'h0,         32'h2,         32'h44,        1'b1, 32'h1002});
        vecs.push_back('{OP_JAL,   4'd11, 32'h80, 32'h0,         32'h0,         32'hFFFF_FFF0, 32'h84,        1'b1, 32'h70});

        // Reset held from time zero
        stepCycle();
        checkCdb("reset_hold", 1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
        #3 rst_n = 1'b1;

        // Async reset mid-cycle after a jump pulse
        applyStimulus(OP_JAL, 4'd12, 32'h300, 32'h0, 32'h0, 32'h10);
        stepCycle();
        checkCdb("pre_reset_jal", 1'b1, 4'd12, 32'h304, 1'b1, 32'h310);
        #2 rst_n = 1'b0;
        #1;
        checkCdb("async_reset", 1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
        applyStimulus(OP_NOP, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkOutput($sformatf("post_reset_nop%0d.valid", i), {31'd0, bus_if.alu_has_result}, 32'd0);
        end

        // Directed vectors issued back to back
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].op, vecs[i].rd, vecs[i].pc, vecs[i].vi, vecs[i].vj, vecs[i].imm);
            stepCycle();
            checkCdb($sformatf("vec%0d", i), 1'b1, vecs[i].rd, vecs[i].exp_result, vecs[i].exp_jump, vecs[i].exp_target);
        end

        // Unknown encoding behaves as NOP
        applyStimulus(6'd63, 4'd13, 32'h500, 32'h1, 32'h1, 32'h1);
        stepCycle();
        checkOutput("unknown_op.valid", {31'd0, bus_if.alu_has_result}, 32'd0);
        checkOutput("unknown_op.jump",  {31'd0, bus_if.jump_flag}, 32'd0);

        // Back-to-back ADDI then NOP
        applyStimulus(OP_ADDI, 4'd1, 32'h600, 32'd10, 32'd0, 32'd1);
        stepCycle();
        checkCdb("b2b_first", 1'b1, 4'd1, 32'd11, 1'b0, 32'h604);
        applyStimulus(OP_ADDI, 4'd2, 32'h604, 32'd20, 32'd0, 32'hFFFF_FFFF);
        stepCycle();
        checkCdb("b2b_second", 1'b1, 4'd2, 32'd19, 1'b0, 32'h608);
        applyStimulus(OP_NOP, 4'd0, 32'h608, 32'd0, 32'd0, 32'd0);
        stepCycle();
        checkOutput("b2b_nop.valid", {31'd0, bus_if.alu_has_result}, 32'd0);

        // Rollback discards the op on its edge and clears the previous pulse
        applyStimulus(OP_JAL, 4'd7, 32'h700, 32'h0, 32'h0, 32'h40);
        stepCycle();
        checkCdb("rb_before", 1'b1, 4'd7, 32'h704, 1'b1, 32'h740);
        applyStimulus(OP_JAL, 4'd8, 32'h800, 32'h0, 32'h0, 32'h40);
        rollback_signal = 1'b1;
        stepCycle();
        checkOutput("rb_edge.valid", {31'd0, bus_if.alu_has_result}, 32'd0);
        checkOutput("rb_edge.jump",  {31'd0, bus_if.jump_flag}, 32'd0);
        rollback_signal = 1'b0;
        applyStimulus(OP_NOP, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        stepCycle();
        checkOutput("rb_after.valid", {31'd0, bus_if.alu_has_result}, 32'd0);

        // Pause holds the pulse and ignores inputs
        applyStimulus(OP_ADD, 4'd9, 32'h900, 32'd3, 32'd4, 32'd0);
        stepCycle();
        checkCdb("pause_start", 1'b1, 4'd9, 32'd7, 1'b0, 32'h904);
        rdy = 1'b0;
        applyStimulus(OP_JAL, 4'd10, 32'hA00, 32'd1, 32'd1, 32'h8);
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkCdb($sformatf("pause_hold%0d", i), 1'b1, 4'd9, 32'd7, 1'b0, 32'h904);
        end
        rdy = 1'b1;
        applyStimulus(OP_NOP, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        stepCycle();
        checkOutput("pause_release.valid", {31'd0, bus_if.alu_has_result}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
